// File: rtl/key_load_ctrl.sv
// Key-load sequencer for an XOR-locked core: streams key chunks plus an XOR checksum,
// commits the key atomically on a checksum match, and gates the core outputs until armed.
module key_load_ctrl #(
   parameter int KEY_W   = 64,
   parameter int CHUNK_W = 8,
   parameter int OUT_W   = 7,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_start,
   input  logic               kin_valid,
   output logic               kin_ready,
   input  logic [CHUNK_W-1:0] kin_data,
   input  logic               kin_last,
   output logic [KEY_W-1:0]   key_out,
   output logic               key_valid,
   output logic               busy,
   output logic               err,
   input  logic [OUT_W-1:0]   core_in,
   output logic [OUT_W-1:0]   core_out
);

   localparam int NBEATS = KEY_W / CHUNK_W;
   localparam int CNT_W  = $clog2(NBEATS + 1);
   localparam int TMO_W  = $clog2(TIMEOUT + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_ARMED,
      S_FAULT
   } state_e;

   state_e             state_q, state_d;
   logic [KEY_W-1:0]   shadow_q, shadow_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CHUNK_W-1:0] csum_q, csum_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [KEY_W-1:0]   key_out_q, key_out_d;
   logic               key_valid_q, key_valid_d;
   logic [OUT_W-1:0]   core_out_q, core_out_d;

   logic in_load;
   logic accept;
   logic tmo_hit;

   assign in_load   = (state_q == S_LOAD) || (state_q == S_CHECK);
   assign kin_ready = in_load;
   assign busy      = in_load;
   assign err       = (state_q == S_FAULT);
   assign accept    = kin_valid && kin_ready;
   // Fires on the edge that would bring the idle count up to TIMEOUT.
   assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));

   assign key_out   = key_out_q;
   assign key_valid = key_valid_q;
   assign core_out  = core_out_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_d     = state_q;
      shadow_d    = shadow_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      tmo_d       = tmo_q;
      key_out_d   = key_out_q;
      key_valid_d = key_valid_q;
      core_out_d  = key_valid_q ? core_in : '0;

      if (load_start) begin
         // A (re)start wipes all load progress and hides any previously armed key.
         state_d     = S_LOAD;
         shadow_d    = '0;
         cnt_d       = '0;
         csum_d      = '0;
         tmo_d       = '0;
         key_out_d   = '0;
         key_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (accept) begin
                  shadow_d = {shadow_q[KEY_W-CHUNK_W-1:0], kin_data};
                  csum_d   = csum_q ^ kin_data;
                  cnt_d    = cnt_q + 1'b1;
                  tmo_d    = '0;
                  if (kin_last)
                     state_d = S_FAULT;
                  else if (cnt_q == CNT_W'(NBEATS - 1))
                     state_d = S_CHECK;
               end else if (tmo_hit) begin
                  state_d = S_FAULT;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            S_CHECK: begin
               if (accept) begin
                  tmo_d = '0;
                  if (kin_last && (kin_data == csum_q)) begin
                     state_d     = S_ARMED;
                     key_out_d   = shadow_q;
                     key_valid_d = 1'b1;
                  end else begin
                     state_d = S_FAULT;
                  end
               end else if (tmo_hit) begin
                  state_d = S_FAULT;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         shadow_q    <= '0;
         cnt_q       <= '0;
         csum_q      <= '0;
         tmo_q       <= '0;
         key_out_q   <= '0;
         key_valid_q <= 1'b0;
         core_out_q  <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         tmo_q       <= tmo_d;
         key_out_q   <= key_out_d;
         key_valid_q <= key_valid_d;
         core_out_q  <= core_out_d;
      end
   end

endmodule
